// File: rtl/ball_motion_ctrl.sv
// Ball position controller: accepts one move command at a time over valid/ready and
// applies it during vertical blank, so the renderer never sees a mid-frame position change.
module ball_motion_ctrl #(
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_RADIUS   = 20,
    parameter int STEP_PX       = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [10:0]                      i_h_coord,
    input  logic [9:0]                       i_v_coord,
    input  logic                             i_move_valid,
    input  logic [3:0]                       i_move_dir,
    output logic                             o_move_ready,
    output logic [$clog2(SCREEN_WIDTH)-1:0]  o_screen_ball_x,
    output logic [$clog2(SCREEN_HEIGHT)-1:0] o_screen_ball_y,
    output logic                             o_frame_tick
);

    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PENDING  = 2'd1;
    localparam logic [1:0] S_UPDATE_X = 2'd2;
    localparam logic [1:0] S_UPDATE_Y = 2'd3;

    localparam logic [9:0]        V_BLANK_START = 10'(SCREEN_HEIGHT);
    localparam logic signed [11:0] STEP   = 12'(STEP_PX);
    localparam logic signed [11:0] POS_LO = 12'(BALL_RADIUS);
    localparam logic signed [11:0] X_HI   = 12'(SCREEN_WIDTH - 1 - BALL_RADIUS);
    localparam logic signed [11:0] Y_HI   = 12'(SCREEN_HEIGHT - 1 - BALL_RADIUS);
    localparam logic [XW-1:0]     X_RESET = XW'(SCREEN_WIDTH / 2);
    localparam logic [YW-1:0]     Y_RESET = YW'(SCREEN_HEIGHT / 2);

    logic [1:0]    state_q, state_d;
    logic [3:0]    dir_q, dir_d;
    logic          pend_armed_q, pend_armed_d;
    logic          vblank_q, vblank_d;
    logic          frame_tick_q, frame_tick_d;
    logic [XW-1:0] ball_x_q, ball_x_d;
    logic [YW-1:0] ball_y_q, ball_y_d;

    logic signed [11:0] dx, dy;
    logic signed [11:0] x_sum, y_sum;
    logic [XW-1:0]      x_next;
    logic [YW-1:0]      y_next;

    // Horizontal position plays no part in detecting vertical blank.
    logic h_coord_unused;
    assign h_coord_unused = ^i_h_coord;

    function automatic logic signed [11:0] clamp12(
        input logic signed [11:0] val,
        input logic signed [11:0] lo,
        input logic signed [11:0] hi
    );
        if (val < lo) begin
            return lo;
        end else if (val > hi) begin
            return hi;
        end else begin
            return val;
        end
    endfunction

    always_comb begin
        vblank_d     = (i_v_coord >= V_BLANK_START);
        frame_tick_d = vblank_d & ~vblank_q;
    end

    // Opposing direction bits cancel because both contributions are summed.
    always_comb begin
        dx = '0;
        dy = '0;
        if (dir_q[0]) dx = dx + STEP;
        if (dir_q[1]) dx = dx - STEP;
        if (dir_q[2]) dy = dy + STEP;
        if (dir_q[3]) dy = dy - STEP;
        x_sum  = $signed(12'(ball_x_q)) + dx;
        y_sum  = $signed(12'(ball_y_q)) + dy;
        x_next = XW'(clamp12(x_sum, POS_LO, X_HI));
        y_next = YW'(clamp12(y_sum, POS_LO, Y_HI));
    end

    // A command accepted on the very edge the frame tick rises must skip that tick,
    // so PENDING only honours a tick after it has spent one cycle armed.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        pend_armed_d = pend_armed_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        case (state_q)
            S_IDLE: begin
                if (i_move_valid) begin
                    dir_d        = i_move_dir;
                    pend_armed_d = 1'b0;
                    state_d      = S_PENDING;
                end
            end
            S_PENDING: begin
                pend_armed_d = 1'b1;
                if (frame_tick_q && pend_armed_q) begin
                    state_d = S_UPDATE_X;
                end
            end
            S_UPDATE_X: begin
                ball_x_d = x_next;
                state_d  = S_UPDATE_Y;
            end
            S_UPDATE_Y: begin
                ball_y_d = y_next;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            dir_q        <= '0;
            pend_armed_q <= 1'b0;
            vblank_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            ball_x_q     <= X_RESET;
            ball_y_q     <= Y_RESET;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            pend_armed_q <= pend_armed_d;
            vblank_q     <= vblank_d;
            frame_tick_q <= frame_tick_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
        end
    end

    assign o_move_ready    = (state_q == S_IDLE);
    assign o_screen_ball_x = ball_x_q;
    assign o_screen_ball_y = ball_y_q;
    assign o_frame_tick    = frame_tick_q;

endmodule
